// File: rtl/cr_write_back_arbiter.sv
// Round-robin arbiter for the shared CR write-back port: grants one requesting
// execution unit per cycle and holds its result in a valid/ready output register.
module cr_write_back_arbiter #(
  parameter int RS_ID_WIDTH   = 5,
  parameter int ARBITER_DEPTH = 4,
  localparam int PW = $clog2(ARBITER_DEPTH)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [ARBITER_DEPTH-1:0]                   i_cr_input_valid,
  output logic [ARBITER_DEPTH-1:0]                   o_cr_input_ready,
  input  logic [ARBITER_DEPTH-1:0][RS_ID_WIDTH-1:0]  i_cr_rs_id_in,
  input  logic [ARBITER_DEPTH-1:0][7:0]              i_cr_field_mask_in,
  input  logic [ARBITER_DEPTH-1:0][31:0]             i_cr_result_in,
  output logic                                       o_cr_output_valid,
  input  logic                                       i_cr_output_ready,
  output logic [RS_ID_WIDTH-1:0]                     o_cr_rs_id_out,
  output logic [7:0]                                 o_cr_field_mask_out,
  output logic [31:0]                                o_cr_result_out,
  output logic [PW-1:0]                              o_cr_grant_out
);

  logic [PW-1:0]          r_pointer_ff;
  logic                   r_valid;
  logic [RS_ID_WIDTH-1:0] r_rs_id;
  logic [7:0]             r_mask;
  logic [31:0]            r_result;
  logic [PW-1:0]          r_grant;

  logic                   w_load_en;
  logic                   w_any_valid;
  logic [PW-1:0]          w_grant;
  logic [PW-1:0]          w_pointer_next;
  logic [PW:0]            w_sum;

  assign w_load_en = ~r_valid | i_cr_output_ready;

  // Search from the pointer upwards; the extra sum bit plus an explicit compare
  // keeps the wrap correct for non-power-of-two depths.
  always_comb begin
    w_grant     = '0;
    w_any_valid = 1'b0;
    w_sum       = '0;
    for (int k = 0; k < ARBITER_DEPTH; k++) begin
      w_sum = {1'b0, r_pointer_ff} + (PW+1)'(k);
      if (w_sum > (PW+1)'(ARBITER_DEPTH-1))
        w_sum = w_sum - (PW+1)'(ARBITER_DEPTH);
      if (!w_any_valid && i_cr_input_valid[w_sum[PW-1:0]]) begin
        w_any_valid = 1'b1;
        w_grant     = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    if (w_grant == PW'(ARBITER_DEPTH-1))
      w_pointer_next = '0;
    else
      w_pointer_next = w_grant + PW'(1);
  end

  always_comb begin
    o_cr_input_ready = '0;
    if (!rst && w_load_en && w_any_valid)
      o_cr_input_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pointer_ff <= '0;
      r_valid      <= 1'b0;
      r_rs_id      <= '0;
      r_mask       <= '0;
      r_result     <= '0;
      r_grant      <= '0;
    end else if (w_load_en) begin
      if (w_any_valid) begin
        r_valid      <= 1'b1;
        r_rs_id      <= i_cr_rs_id_in[w_grant];
        r_mask       <= i_cr_field_mask_in[w_grant];
        r_result     <= i_cr_result_in[w_grant];
        r_grant      <= w_grant;
        r_pointer_ff <= w_pointer_next;
      end else begin
        // Data registers keep stale contents; consumers qualify with valid.
        r_valid <= 1'b0;
      end
    end
  end

  assign o_cr_output_valid   = r_valid;
  assign o_cr_rs_id_out      = r_rs_id;
  assign o_cr_field_mask_out = r_mask;
  assign o_cr_result_out     = r_result;
  assign o_cr_grant_out      = r_grant;

endmodule

// File: tb/tb_cr_write_back_arbiter.sv
// Scoreboarded bench for cr_write_back_arbiter: directed scenarios plus random
// traffic against a queue-based round-robin reference, and a depth-3 wrap check.
module tb_cr_write_back_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // depth-4 instance
  logic [3:0]       pv = '0;
  logic [3:0][4:0]  pid = '0;
  logic [3:0][7:0]  pmask = '0;
  logic [3:0][31:0] pres = '0;
  logic             out_ready = 1'b0;
  logic [3:0]       o_rdy;
  logic             o_valid;
  logic [4:0]       o_id;
  logic [7:0]       o_mask;
  logic [31:0]      o_res;
  logic [1:0]       o_grant;

  cr_write_back_arbiter #(.RS_ID_WIDTH(5), .ARBITER_DEPTH(4)) u4 (
    .clk(clk), .rst(rst),
    .i_cr_input_valid(pv), .o_cr_input_ready(o_rdy),
    .i_cr_rs_id_in(pid), .i_cr_field_mask_in(pmask), .i_cr_result_in(pres),
    .o_cr_output_valid(o_valid), .i_cr_output_ready(out_ready),
    .o_cr_rs_id_out(o_id), .o_cr_field_mask_out(o_mask),
    .o_cr_result_out(o_res), .o_cr_grant_out(o_grant)
  );

  // depth-3 instance
  logic [2:0]       v3 = '0;
  logic [2:0][4:0]  id3 = '0;
  logic [2:0][7:0]  mask3 = '0;
  logic [2:0][31:0] res3 = '0;
  logic             out_ready3 = 1'b1;
  logic [2:0]       rdy3;
  logic             valid3;
  logic [4:0]       oid3;
  logic [7:0]       omask3;
  logic [31:0]      ores3;
  logic [1:0]       grant3;

  cr_write_back_arbiter #(.RS_ID_WIDTH(5), .ARBITER_DEPTH(3)) u3 (
    .clk(clk), .rst(rst),
    .i_cr_input_valid(v3), .o_cr_input_ready(rdy3),
    .i_cr_rs_id_in(id3), .i_cr_field_mask_in(mask3), .i_cr_result_in(res3),
    .o_cr_output_valid(valid3), .i_cr_output_ready(out_ready3),
    .o_cr_rs_id_out(oid3), .o_cr_field_mask_out(omask3),
    .o_cr_result_out(ores3), .o_cr_grant_out(grant3)
  );

  typedef struct packed {
    logic [1:0]  g;
    logic [4:0]  id;
    logic [7:0]  mask;
    logic [31:0] res;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   mptr = 0;
  bit   mvalid = 1'b0;
  bit   rnd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic step();
    logic [3:0] exp_rdy;
    int         acc;
    bit         found;
    int         g;
    exp_t       e;
    @(negedge clk);
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i]    = 1'b1;
          pid[i]   = 5'($urandom);
          pmask[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
          pres[i]  = $urandom;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    #1;
    chk("output_valid", 64'(o_valid), 64'(mvalid));
    exp_rdy = '0;
    acc = -1;
    if (rst) begin
      mvalid = 1'b0;
      mptr   = 0;
      sbq.delete();
    end else if (!mvalid || out_ready) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (mptr + k) % 4;
        if (!found && pv[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      if (found) begin
        exp_rdy[g] = 1'b1;
        e.g = 2'(g); e.id = pid[g]; e.mask = pmask[g]; e.res = pres[g];
        sbq.push_back(e);
        mptr   = (g + 1) % 4;
        mvalid = 1'b1;
        acc    = g;
      end else begin
        mvalid = 1'b0;
      end
    end
    chk("input_ready", 64'(o_rdy), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (acc >= 0) pv[acc] = 1'b0;
  endtask

  // Monitor: the held output must match the scoreboard head; pop when consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && o_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("spurious_output", 64'(o_id), 64'h3f);
        end else begin
          e = sbq[0];
          chk("output_data", 64'({o_grant, o_id, o_mask, o_res}), 64'(e));
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic step3(input logic [2:0] vin, input int g);
    logic [2:0] e;
    e = 3'(1 << g);
    v3 = vin;
    @(negedge clk);
    #1;
    chk("d3_ready", 64'(rdy3), 64'(e));
    @(posedge clk);
    #1;
    chk("d3_grant", 64'(grant3), 64'(g));
    chk("d3_valid", 64'(valid3), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_id", 64'(o_id), 64'd0);
    chk("rst_mask", 64'(o_mask), 64'd0);
    chk("rst_result", 64'(o_res), 64'd0);
    chk("rst_grant", 64'(o_grant), 64'd0);
    pv = 4'hf;
    #1;
    chk("rst_ready", 64'(o_rdy), 64'd0);
    pv = '0;
    rst = 1'b0;

    // round robin with all four requesters continuously valid
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] = 1'b1; pid[i] = 5'(10 + i); pmask[i] = 8'h0f; pres[i] = 32'(i * 16);
      end
      step();
      chk("rr_grant", 64'(o_grant), 64'(k % 4));
      chk("rr_tag", 64'(o_id), 64'(10 + (k % 4)));
    end

    // single requester
    pv = '0;
    pv[2] = 1'b1; pid[2] = 5'd7; pmask[2] = 8'h80; pres[2] = 32'h2000_0000;
    step();
    chk("single_valid", 64'(o_valid), 64'd1);
    chk("single_fields", 64'({o_grant, o_id, o_mask, o_res}), 64'({2'd2, 5'd7, 8'h80, 32'h2000_0000}));
    step();
    chk("idle_valid", 64'(o_valid), 64'd0);

    // back-pressure
    pv[3] = 1'b1; pid[3] = 5'd5; pmask[3] = 8'h01; pres[3] = 32'h0000_0004;
    step();
    out_ready = 1'b0;
    pv[1] = 1'b1; pid[1] = 5'd6; pmask[1] = 8'h02; pres[1] = 32'h0000_0040;
    repeat (3) begin
      step();
      chk("bp_hold_tag", 64'(o_id), 64'd5);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_tag", 64'(o_id), 64'd6);
    chk("bp_next_grant", 64'(o_grant), 64'd1);

    // zero mask
    pv[0] = 1'b1; pid[0] = 5'd3; pmask[0] = 8'h00; pres[0] = 32'hdead_beef;
    step();
    chk("zero_mask_valid", 64'(o_valid), 64'd1);
    chk("zero_mask_mask", 64'(o_mask), 64'd0);

    // reset while a result is held and another request is pending
    pv[1] = 1'b1; pid[1] = 5'd9; pmask[1] = 8'h10; pres[1] = 32'h0001_0000;
    step();
    out_ready = 1'b0;
    pv[2] = 1'b1; pid[2] = 5'd14; pmask[2] = 8'h20; pres[2] = 32'h0020_0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_fields", 64'({o_grant, o_id, o_mask, o_res}), 64'd0);
    pv[3] = 1'b1; pid[3] = 5'd15; pmask[3] = 8'h40; pres[3] = 32'h0400_0000;
    out_ready = 1'b1;
    step();
    chk("postrst_grant", 64'(o_grant), 64'd2);

    // random traffic
    rnd = 1'b1;
    repeat (400) step();
    rnd = 1'b0;
    pv = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    // depth-3 wrap
    step3(3'b010, 1);
    step3(3'b011, 0);
    step3(3'b011, 1);
    step3(3'b111, 2);
    step3(3'b111, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_write_back_arbiter.md
Name: cr_write_back_arbiter

Overview:
Shares the single condition-register write-back port between up to ARBITER_DEPTH execution units that produce CR field updates (compare, record-form ALU, mtcrf, CR logical ops).
- Each cycle it grants one valid requester in round-robin order and captures its result in an output register.
- It presents that result to the CR rename/commit logic with a valid/ready handshake and honours back-pressure.
- It sits beside the GPR/SPR write-back arbiter, between the reservation-station execution units and the CR register file.

Parameters:
RS_ID_WIDTH, 5, width of the reservation-station / tag id carried with each result
ARBITER_DEPTH, 4, number of requesting execution units (>=2; need not be a power of two)

Ports:
clk  input  1  clock
rst  input  1  reset
cr_input_valid  input  1 per requester [0:ARBITER_DEPTH-1]  requester i holds a CR result
cr_input_ready  output  1 per requester [0:ARBITER_DEPTH-1]  result of requester i is accepted this cycle
cr_rs_id_in  input  RS_ID_WIDTH per requester  tag of requester i's result
cr_field_mask_in  input  8 per requester  bit k set = CR field k (CR[4k:4k+3]) written
cr_result_in  input  32 per requester  full 32-bit CR image; only masked fields meaningful
cr_output_valid  output  1  output register holds a result
cr_output_ready  input  1  downstream consumes the output this cycle
cr_rs_id_out  output  RS_ID_WIDTH  tag of the held result
cr_field_mask_out  output  8  field mask of the held result
cr_result_out  output  32  CR image of the held result
cr_grant_out  output  $clog2(ARBITER_DEPTH)  index of the requester whose result is held (debug/perf)

Behaviour:
- Reset (rst synchronous, active-high, clock clk):
  - pointer_ff=0; cr_output_valid=0; cr_rs_id_out=0; cr_field_mask_out=0; cr_result_out=0; cr_grant_out=0.
  - All cr_input_ready are 0 while rst is high.
- Output register:
  - load_en = ~cr_output_valid | cr_output_ready.
  - When load_en=0, all outputs hold unchanged and every cr_input_ready=0.
- Grant selection (combinational):
  - Search indices pointer_ff, pointer_ff+1, ..., wrapping to 0 after ARBITER_DEPTH-1. The pointer_ff index itself has highest priority.
  - The first index with cr_input_valid=1 is the grant g.
  - Wrap uses an explicit compare against ARBITER_DEPTH-1, not a bit-width overflow, so that non-power-of-two depths work.
- Accept:
  - If load_en and any valid: cr_input_ready[g]=1 and all others 0.
  - Next cycle: cr_output_valid=1; outputs = requester g's rs_id, mask and result; cr_grant_out=g.
  - pointer_ff <= g+1, wrapping to 0 when g=ARBITER_DEPTH-1.
- Idle:
  - If load_en and no valid: cr_output_valid <= 0 and pointer_ff unchanged.
  - Data outputs may hold stale values; downstream must qualify them with valid.
- Latency: 1 cycle from acceptance to cr_output_valid.
- Throughput: 1 result/cycle while cr_output_ready=1.
- Simultaneous consume and load: when cr_output_valid=1 and cr_output_ready=1 in the same cycle as a grant, the old result is consumed and the new one loaded. No bubble.
- Ready-valid rules:
  - cr_input_ready[i] depends on the cr_input_valid vector and on cr_output_ready.
  - No input may have a combinational path to itself other than through its own valid.
  - A requester must keep its valid and data stable until it sees ready.
- Mask handling:
  - The field mask is passed through unmodified. A zero mask is legal and forwarded as a normal result, so the tag completes.
  - No merging of results from different requesters.
- Fairness: with all requesters continuously valid and no back-pressure, grants rotate 0,1,...,DEPTH-1,0,...
  - Any continuously valid requester is granted within ARBITER_DEPTH accepted transfers.
- Reset mid-operation: a held, unconsumed result is discarded (valid=0 next cycle); pending requests are unaffected and re-arbitrated from index 0.

Test Plan:
- Single requester: valid[2]=1, rs_id=7, mask=0x80, result=0x2000_0000, cr_output_ready=1 -> cycle after accept: output_valid=1, rs_id_out=7, mask_out=0x80, result_out=0x2000_0000, grant_out=2, pointer_ff=3; valid drops -> output_valid=0.
- Round-robin (DEPTH=4): all four valid with tags 10..13, ready=1 -> outputs tags 10,11,12,13,10 on consecutive cycles; exactly one cr_input_ready high per cycle.
- Back-pressure: result for tag 5 held, cr_output_ready=0 for 3 cycles with valid[1]=1 -> outputs stable at tag 5 and cr_input_ready[1]=0 throughout; ready=1 -> tag 5 consumed and requester 1 accepted the same cycle, then appears next cycle.
- Wrap, non-power-of-two (DEPTH=3): pointer_ff=2, valid[0]=valid[1]=1, valid[2]=0 -> grant 0, then pointer_ff=1 -> grant 1, then pointer_ff=2.
- Zero mask: mask=0x00, tag 3 -> forwarded with mask_out=0x00, output_valid=1.
- Reset mid-operation: output holds tag 9 unconsumed, rst pulsed one cycle -> output_valid=0 and all outputs 0; pointer_ff=0; first post-reset grant is the lowest valid index.
